// File: rtl/fpu_host_if_if.sv
// Host-side 8-bit register bus of the FPU front end: byte-wide read/write
// strobes plus the cmd_end / end_ack completion handshake.
interface fpu_host_if_if #(parameter int ADDR_W = 6);
  logic [7:0]        databus_in;
  logic [7:0]        databus_out;
  logic [ADDR_W-1:0] addr;
  logic              cs;
  logic              rd;
  logic              wr;
  logic              end_ack;
  logic              cmd_end;
  logic              busy;

  modport master (output databus_in, addr, cs, rd, wr, end_ack,
                  input  databus_out, cmd_end, busy);
  modport slave  (input  databus_in, addr, cs, rd, wr, end_ack,
                  output databus_out, cmd_end, busy);
endinterface

// File: rtl/fpu_host_if.sv
// Queued host-bus front end for the FPU core: byte-wise operand registers,
// a command FIFO and a sequencer that issues one command at a time.
module fpu_host_if #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              arst,
  fpu_host_if_if.slave      bus,
  output logic              core_start,
  output logic [7:0]        core_op,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result
);
  localparam int NB    = DATA_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 8 + 2 * DATA_W;
  localparam logic [ADDR_W-1:0] CMD_ADDR  = ADDR_W'(2 * NB);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(2 * NB + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic                r_wr_prev, r_ack_prev, r_ovf;
  logic [DATA_W-1:0]   r_a, r_b, r_result, r_core_a, r_core_b;
  logic [7:0]          r_core_op;
  logic [ENT_W-1:0]    r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_wr_evt, w_ack_rise, w_full, w_pop, w_cmd_wr, w_push, w_drop;
  logic [7:0]          w_status, w_rd_byte;

  // A write is the first sampled cs=0/wr=0 after wr was seen high.
  assign w_wr_evt   = !bus.cs && !bus.wr && r_wr_prev;
  assign w_ack_rise = bus.end_ack && !r_ack_prev;
  assign w_full     = (r_count == CNT_FULL);
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_cmd_wr   = w_wr_evt && (bus.addr == CMD_ADDR);
  assign w_push     = w_cmd_wr && (!w_full || w_pop);
  assign w_drop     = w_cmd_wr && !w_push;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_wr_prev  <= 1'b1;
      r_ack_prev <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_wr_prev  <= bus.wr;
      r_ack_prev <= bus.end_ack;
      if (w_wr_evt) begin
        for (int k = 0; k < NB; k++) begin
          if (bus.addr == ADDR_W'(k))      r_a[k*8 +: 8] <= bus.databus_in;
          if (bus.addr == ADDR_W'(NB + k)) r_b[k*8 +: 8] <= bus.databus_in;
        end
      end
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_wr_evt && bus.addr == STAT_ADDR && bus.databus_in[3])
        r_ovf <= 1'b0;
    end
  end

  // Queue storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wptr] <= {bus.databus_in, r_a, r_b};
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_core_op <= '0;
      r_core_a  <= '0;
      r_core_b  <= '0;
      r_result  <= '0;
    end else begin
      if (w_pop)
        {r_core_op, r_core_a, r_core_b} <= r_fifo[r_rptr];
      if (r_state == S_WAIT && core_done)
        r_result <= core_result;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_state_next = S_START;
      S_START: w_state_next = S_WAIT;
      S_WAIT:  if (core_done) w_state_next = S_DONE;
      S_DONE:  if (w_ack_rise) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign core_start  = (r_state == S_START);
  assign core_op     = r_core_op;
  assign core_a      = r_core_a;
  assign core_b      = r_core_b;
  assign bus.cmd_end = (r_state == S_DONE);
  assign bus.busy    = (r_state != S_IDLE) || (r_count != '0);
  assign w_status    = {4'(r_count), r_ovf, w_full, bus.cmd_end, bus.busy};

  always_comb begin
    w_rd_byte = 8'h00;
    if (!bus.cs && !bus.rd) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.addr == ADDR_W'(k))          w_rd_byte = r_a[k*8 +: 8];
        if (bus.addr == ADDR_W'(NB + k))     w_rd_byte = r_b[k*8 +: 8];
        if (bus.addr == ADDR_W'(3 * NB + k)) w_rd_byte = r_result[k*8 +: 8];
      end
      if (bus.addr == STAT_ADDR) w_rd_byte = w_status;
    end
  end

  assign bus.databus_out = w_rd_byte;
endmodule

// File: tb/tb_fpu_host_if.sv
// Bench for fpu_host_if: a 32-bit instance checked every cycle against a
// command-queue model, plus a 64-bit / depth-2 instance checked directly.
module tb_fpu_host_if;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  fpu_host_if_if #(.ADDR_W(6)) bus32 ();
  fpu_host_if_if #(.ADDR_W(6)) bus64 ();

  logic        core_start, core_done;
  logic [7:0]  core_op;
  logic [31:0] core_a, core_b, core_result;
  logic        s64, d64;
  logic [7:0]  op64;
  logic [63:0] a64, b64, r64;

  fpu_host_if #(.DATA_W(32), .FIFO_DEPTH(4), .ADDR_W(6)) u32 (
    .clk(clk), .arst(arst), .bus(bus32), .core_start(core_start), .core_op(core_op),
    .core_a(core_a), .core_b(core_b), .core_done(core_done), .core_result(core_result));

  fpu_host_if #(.DATA_W(64), .FIFO_DEPTH(2), .ADDR_W(6)) u64 (
    .clk(clk), .arst(arst), .bus(bus64), .core_start(s64), .core_op(op64),
    .core_a(a64), .core_b(b64), .core_done(d64), .core_result(r64));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fcore(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h42C7FAE1 && b == 32'h4331E148) return 32'h3FE3B58C;
    return a + b + {24'h0, op};
  endfunction

  // Core stub: answers core_lat cycles after a start (0 = stalled).
  int          core_lat = 0;
  int          force_req = 0;
  int          force_seen = 0;
  int          pend = 0;
  logic [31:0] pres;
  initial begin
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      #1;
      core_done = 1'b0;
      if (!arst) pend = 0;
      else if (force_req != force_seen) begin
        force_seen = force_req;
        core_done = 1'b1;
        core_result = 32'hDEADBEEF;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_done = 1'b1;
          core_result = pres;
        end
      end else if (core_start && core_lat > 0) begin
        pend = core_lat;
        pres = fcore(core_op, core_a, core_b);
      end
    end
  end

  // Model: queued-but-not-started commands, one outstanding command, result flag.
  typedef struct {logic [7:0] op; logic [31:0] a; logic [31:0] b;} cmd_t;
  cmd_t        q_m[$];
  cmd_t        m_c;
  logic [31:0] a_m = '0, b_m = '0, res_m = '0;
  bit          out_m = 0, rdy_m = 0, ovf_m = 0, wrp_m = 1, ackp_m = 0, start_prev = 0;

  always @(posedge clk) begin
    if (!arst) begin
      q_m.delete();
      a_m = '0; b_m = '0; out_m = 0; rdy_m = 0; ovf_m = 0; wrp_m = 1; ackp_m = 0;
    end else begin
      if (out_m && !rdy_m && core_done) begin
        rdy_m = 1;
        res_m = core_result;
      end else if (rdy_m && bus32.end_ack && !ackp_m) begin
        rdy_m = 0;
        out_m = 0;
      end
      ackp_m = bus32.end_ack;
      if (!bus32.cs && !bus32.wr && wrp_m) begin
        if (bus32.addr < 4) a_m[bus32.addr*8 +: 8] = bus32.databus_in;
        else if (bus32.addr < 8) b_m[(bus32.addr-4)*8 +: 8] = bus32.databus_in;
        else if (bus32.addr == 8) begin
          if (q_m.size() < FD) begin
            m_c.op = bus32.databus_in; m_c.a = a_m; m_c.b = b_m;
            q_m.push_back(m_c);
          end else ovf_m = 1;
        end else if (bus32.addr == 9 && bus32.databus_in[3]) ovf_m = 0;
      end
      wrp_m = bus32.wr;
    end
    #2;
    if (!arst) begin
      chk("rst_core_start", core_start, 0);
      chk("rst_cmd_end", bus32.cmd_end, 0);
      chk("rst_busy", bus32.busy, 0);
      chk("rst_core_op", core_op, 0);
      chk("rst_core_a", core_a, 0);
      chk("rst_core_b", core_b, 0);
    end else begin
      if (core_start) begin
        chk("start_one_cycle", start_prev, 0);
        chk("start_after_ack", out_m, 0);
        chk("start_queue_nonempty", 64'(q_m.size() != 0), 1);
        if (q_m.size() != 0) begin
          chk("start_op", core_op, q_m[0].op);
          chk("start_a", core_a, q_m[0].a);
          chk("start_b", core_b, q_m[0].b);
          void'(q_m.pop_front());
        end
        out_m = 1;
      end
      chk("cmd_end", bus32.cmd_end, rdy_m);
      chk("busy", bus32.busy, (q_m.size() != 0) || out_m);
    end
    start_prev = core_start;
  end

  task automatic wr_b(input bit w64, input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    if (w64) begin bus64.addr = a; bus64.databus_in = d; bus64.cs = 0; bus64.wr = 0; end
    else     begin bus32.addr = a; bus32.databus_in = d; bus32.cs = 0; bus32.wr = 0; end
    @(negedge clk);
    if (w64) begin bus64.cs = 1; bus64.wr = 1; end
    else     begin bus32.cs = 1; bus32.wr = 1; end
  endtask

  task automatic rd_b(input bit w64, input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    if (w64) begin bus64.addr = a; bus64.cs = 0; bus64.rd = 0; end
    else     begin bus32.addr = a; bus32.cs = 0; bus32.rd = 0; end
    #1;
    d = w64 ? bus64.databus_out : bus32.databus_out;
    bus64.cs = 1; bus64.rd = 1; bus32.cs = 1; bus32.rd = 1;
  endtask

  task automatic chk_rd(input string name, input bit w64, input logic [5:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd_b(w64, a, d);
    chk(name, d, exp);
  endtask

  task automatic wait_end(input bit w64, input int lim);
    int n = 0;
    while ((w64 ? bus64.cmd_end : bus32.cmd_end) !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_end_within_bound", w64 ? bus64.cmd_end : bus32.cmd_end, 1);
  endtask

  task automatic ack(input bit w64);
    @(negedge clk);
    if (w64) bus64.end_ack = 1; else bus32.end_ack = 1;
    @(negedge clk);
    if (w64) bus64.end_ack = 0; else bus32.end_ack = 0;
  endtask

  logic [7:0]  byt;
  logic [31:0] r32;
  logic [63:0] exp64;

  initial begin
    bus32.cs = 1; bus32.rd = 1; bus32.wr = 1; bus32.end_ack = 0; bus32.addr = '0; bus32.databus_in = '0;
    bus64.cs = 1; bus64.rd = 1; bus64.wr = 1; bus64.end_ack = 0; bus64.addr = '0; bus64.databus_in = '0;
    d64 = 0; r64 = '0;
    repeat (3) @(negedge clk);
    arst = 1;

    // Reset state
    chk("rst_bus_idle", bus32.databus_out, 8'h00);
    chk_rd("rst_status", 0, 6'h09, 8'h00);

    // Single divide with exact start latency
    core_lat = 10;
    wr_b(0, 6'h04, 8'h48); wr_b(0, 6'h05, 8'hE1); wr_b(0, 6'h06, 8'h31); wr_b(0, 6'h07, 8'h43);
    wr_b(0, 6'h00, 8'hE1); wr_b(0, 6'h01, 8'hFA); wr_b(0, 6'h02, 8'hC7); wr_b(0, 6'h03, 8'h42);
    wr_b(0, 6'h08, 8'h03);
    chk("div_no_start_yet", core_start, 0);
    @(negedge clk);
    chk("div_start", core_start, 1);
    chk("div_core_a", core_a, 32'h42C7FAE1);
    chk("div_core_b", core_b, 32'h4331E148);
    chk("div_core_op", core_op, 8'h03);
    @(negedge clk);
    chk("div_start_drop", core_start, 0);
    wait_end(0, 40);
    chk_rd("div_status_pre_ack", 0, 6'h09, 8'h03);
    chk_rd("div_res0", 0, 6'h0C, 8'h8C);
    chk_rd("div_res1", 0, 6'h0D, 8'hB5);
    chk_rd("div_res2", 0, 6'h0E, 8'hE3);
    chk_rd("div_res3", 0, 6'h0F, 8'h3F);
    ack(0);
    chk_rd("div_status_post_ack", 0, 6'h09, 8'h00);

    // Queue of three, delivered in order
    core_lat = 4;
    for (int k = 0; k < 3; k++) begin
      wr_b(0, 6'h00, 8'(8'h10 + k));
      wr_b(0, 6'h08, 8'h01);
    end
    rd_b(0, 6'h09, byt);
    chk("queue_count_after_pop", byt[7:4], 4'd2);
    for (int k = 0; k < 3; k++) begin
      wait_end(0, 60);
      for (int i = 0; i < 4; i++) begin
        rd_b(0, 6'(12 + i), byt);
        r32[i*8 +: 8] = byt;
      end
      chk("queue_result_order", r32, fcore(8'h01, {24'h42C7FA, 8'(8'h10 + k)}, 32'h4331E148));
      ack(0);
    end
    chk("queue_busy_after_last_ack", bus32.busy, 0);

    // Overflow with stalled core
    core_lat = 0;
    for (int k = 0; k < 5; k++) wr_b(0, 6'h08, 8'(8'h20 + k));
    chk_rd("ovf_full_status", 0, 6'h09, 8'h45);
    wr_b(0, 6'h08, 8'h2F);
    chk_rd("ovf_sticky_set", 0, 6'h09, 8'h4D);
    wr_b(0, 6'h09, 8'h08);
    chk_rd("ovf_cleared", 0, 6'h09, 8'h45);

    // Reset mid-WAIT with two queued, then a stale core_done
    @(negedge clk); arst = 0;
    @(negedge clk); arst = 1;
    for (int k = 0; k < 3; k++) wr_b(0, 6'h08, 8'(8'h30 + k));
    chk_rd("pre_reset_status", 0, 6'h09, 8'h21);
    @(negedge clk); arst = 0;
    #1;
    chk("async_rst_busy", bus32.busy, 0);
    chk("async_rst_core_start", core_start, 0);
    @(negedge clk); arst = 1;
    force_req++;
    repeat (3) @(negedge clk);
    chk("stale_done_cmd_end", bus32.cmd_end, 0);
    chk_rd("stale_done_status", 0, 6'h09, 8'h00);

    // end_ack held high across two completions
    core_lat = 3;
    wr_b(0, 6'h08, 8'h41);
    wr_b(0, 6'h08, 8'h42);
    wait_end(0, 40);
    @(negedge clk); bus32.end_ack = 1;
    repeat (15) @(negedge clk);
    chk("held_ack_second_pending", bus32.cmd_end, 1);
    bus32.end_ack = 0;
    @(negedge clk); bus32.end_ack = 1;
    @(negedge clk); bus32.end_ack = 0;
    chk("held_ack_retoggled", bus32.cmd_end, 0);
    chk("held_ack_busy", bus32.busy, 0);

    // 64-bit instance, depth 2
    for (int i = 0; i < 8; i++) wr_b(1, 6'(i), 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 8; i++) wr_b(1, 6'(8 + i), 8'(8'hA0 + i));
    wr_b(1, 6'h10, 8'h05);
    begin
      int n = 0;
      while (s64 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    end
    chk("w64_start", s64, 1);
    chk("w64_core_a", a64, 64'h8877665544332211);
    chk("w64_core_b", b64, 64'hA7A6A5A4A3A2A1A0);
    chk("w64_core_op", op64, 8'h05);
    @(negedge clk); d64 = 1; r64 = 64'h0123456789ABCDEF;
    @(negedge clk); d64 = 0;
    wait_end(1, 10);
    exp64 = 64'h0123456789ABCDEF;
    for (int i = 0; i < 8; i++) chk_rd("w64_result_byte", 1, 6'(24 + i), exp64[i*8 +: 8]);
    ack(1);
    chk("w64_busy_after_ack", bus64.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "timeout");
  end
endmodule
